ff2_sync: RTL and testbench



---
 rtl/ff2_sync_pkg.sv | 13 +
 rtl/ff2_sync_bit.sv | 46 ++++
 rtl/ff2_sync.sv | 39 +++
 tb/tb_ff2_sync.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ff2_sync_pkg.sv
// Shared constants for the ff2_sync level synchroniser family.
// The legality helper lets every file in the family reject a bad chain depth the same way.
package ff2_sync_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SYNC_STAGES_MIN     = 2;
    localparam int SYNC_STAGES_MAX     = 4;

    function automatic bit stages_legal(input int stages);
        return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/ff2_sync_bit.sv
// Single-bit synchroniser chain of STAGES flops.
// Every flop uses the same clock edge, which is chosen by NEG_EDGE.
module ff2_sync_bit
    import ff2_sync_pkg::*;
#(
    parameter int STAGES      = SYNC_STAGES_DEFAULT,
    parameter bit NEG_EDGE    = 1'b0,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $fatal(1, "ff2_sync_bit: STAGES=%0d outside legal range %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    // The power-up value makes out defined before the first reset.
    // The attributes keep the chain as discrete flops: no retiming and no shift-register packing.
    (* ASYNC_REG = "TRUE", keep = "true", shreg_extract = "no" *)
    logic [STAGES-1:0] stage = {STAGES{RESET_VALUE}};

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge clk) begin
            if (rst) begin
                stage <= {STAGES{RESET_VALUE}};
            end else begin
                stage <= {stage[STAGES-2:0], in};
            end
        end
    end else begin : g_pos
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= {STAGES{RESET_VALUE}};
            end else begin
                stage <= {stage[STAGES-2:0], in};
            end
        end
    end

    assign out = stage[STAGES-1];

endmodule

// File: rtl/ff2_sync.sv
// WIDTH-bit level synchroniser built from independent single-bit chains.
// There is no coherency between bits, so a multi-bit change may be seen split across edges.
module ff2_sync
    import ff2_sync_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = SYNC_STAGES_DEFAULT,
    parameter bit               NEG_EDGE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $fatal(1, "ff2_sync: STAGES=%0d outside legal range %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "ff2_sync: WIDTH=%0d must be at least 1", WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff2_sync_bit #(
            .STAGES      (STAGES),
            .NEG_EDGE    (NEG_EDGE),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .in  (in[i]),
            .out (out[i])
        );
    end

endmodule

// File: tb/tb_ff2_sync.sv
// Bench for ff2_sync: rising-edge, falling-edge and wide instances, plus a 4-phase handshake loop.
// Expected outputs come from a sampled-history model: out after an edge is the input from STAGES-1 edges earlier,
// or the reset value when any edge in that window had reset asserted.
module tb_ff2_sync;

    logic clk = 1'b0;
    logic in_clk = 1'b0;
    logic bck = 1'b0;

    always #5   clk    = ~clk;
    always #100 in_clk = ~in_clk;
    always #200 bck    = ~bck;

    logic       p_rst = 1'b1;
    logic       p_in  = 1'b0;
    logic [3:0] w_in  = 4'h5;
    logic       n_rst = 1'b1;
    logic       n_in  = 1'b0;
    logic       p_out;
    logic [3:0] w_out;
    logic       n_out;

    logic       hs_rst = 1'b1;
    logic       req = 1'b0;
    logic       req_bck;
    logic       ack;
    logic       ack_in;

    int checks = 0;
    int errors = 0;
    int ack_rises = 0;
    int ack_falls = 0;

    ff2_sync #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b0), .RESET_VALUE(1'b0)) u_p (
        .clk(clk), .rst(p_rst), .in(p_in), .out(p_out));

    ff2_sync #(.WIDTH(4), .STAGES(3), .NEG_EDGE(1'b0), .RESET_VALUE(4'hA)) u_w (
        .clk(clk), .rst(p_rst), .in(w_in), .out(w_out));

    ff2_sync #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b1), .RESET_VALUE(1'b0)) u_n (
        .clk(clk), .rst(n_rst), .in(n_in), .out(n_out));

    // The request travels into the bck domain on falling edges, and the acknowledge returns on rising in_clk edges.
    ff2_sync #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b1), .RESET_VALUE(1'b0)) u_hs_req (
        .clk(bck), .rst(hs_rst), .in(req), .out(req_bck));

    ff2_sync #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b0), .RESET_VALUE(1'b0)) u_hs_ack (
        .clk(in_clk), .rst(hs_rst), .in(ack), .out(ack_in));

    assign ack = req_bck;

    always @(posedge ack) ack_rises <= ack_rises + 1;
    always @(negedge ack) ack_falls <= ack_falls + 1;

    // Each entry is one active edge: p history {rst, p_in, w_in[3:0]}, n history {rst, n_in}.
    // The histories are seeded with reset entries to stand for the power-up value.
    logic [5:0] p_hist[$] = '{6'h20, 6'h20, 6'h20};
    logic [1:0] n_hist[$] = '{2'b10, 2'b10};

    function automatic logic exp_p();
        for (int j = 0; j < 2; j++)
            if (p_hist[p_hist.size()-1-j][5]) return 1'b0;
        return p_hist[p_hist.size()-2][4];
    endfunction

    function automatic logic [3:0] exp_w();
        for (int j = 0; j < 3; j++)
            if (p_hist[p_hist.size()-1-j][5]) return 4'hA;
        return p_hist[p_hist.size()-3][3:0];
    endfunction

    function automatic logic exp_n();
        for (int j = 0; j < 2; j++)
            if (n_hist[n_hist.size()-1-j][1]) return 1'b0;
        return n_hist[n_hist.size()-2][0];
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full clk period: the falling-edge half checks n and drives the p inputs; the rising-edge half checks p/w
    // and drives the n inputs. An optional short pulse on p_in lies entirely between two rising edges.
    task automatic applyStimulus(input logic prst, input logic pin, input logic [3:0] win,
                                 input logic nrst, input logic nin, input bit pulse);
        @(negedge clk);
        #1;
        n_hist.push_back({n_rst, n_in});
        checkOutput("n_out_after_negedge", {3'b0, n_out}, {3'b0, exp_n()});
        checkOutput("p_out_stable_on_negedge", {3'b0, p_out}, {3'b0, exp_p()});
        checkOutput("w_out_stable_on_negedge", w_out, exp_w());
        p_rst = prst;
        p_in  = pin;
        w_in  = win;
        @(posedge clk);
        #1;
        p_hist.push_back({p_rst, p_in, w_in});
        checkOutput("p_out_after_posedge", {3'b0, p_out}, {3'b0, exp_p()});
        checkOutput("w_out_after_posedge", w_out, exp_w());
        checkOutput("n_out_stable_on_posedge", {3'b0, n_out}, {3'b0, exp_n()});
        n_rst = nrst;
        n_in  = nin;
        if (pulse) begin
            #1 p_in = 1'b1;
            #2 p_in = pin;
        end
    endtask

    initial begin
        int waited;

        #1;
        checkOutput("powerup_p", {3'b0, p_out}, 4'h0);
        checkOutput("powerup_w", w_out, 4'hA);
        checkOutput("powerup_n", {3'b0, n_out}, 4'h0);

        // Hold reset, then release with every input high to observe latency.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);

        // A single-edge reset while the outputs are high, then release with the inputs still high.
        applyStimulus(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);

        // A pulse shorter than one period that misses every rising edge must never reach p_out.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("short_pulse_lost", {3'b0, p_out}, 4'h0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(7) == 0, 1'($urandom), 4'($urandom),
                          $urandom_range(7) == 0, 1'($urandom), 1'b0);
        end

        // Four-phase handshake across the in_clk and bck domains.
        repeat (3) @(posedge bck);
        hs_rst = 1'b0;
        repeat (3) @(posedge bck);
        for (int iter = 0; iter < 100; iter++) begin
            @(posedge in_clk);
            #1 req = 1'b1;
            waited = 0;
            while (ack_in !== 1'b1 && waited < 20) begin
                @(posedge in_clk);
                #1 waited++;
            end
            checkOutput("hs_ack_rise", {3'b0, ack_in}, 4'h1);
            req = 1'b0;
            waited = 0;
            while (ack_in !== 1'b0 && waited < 20) begin
                @(posedge in_clk);
                #1 waited++;
            end
            checkOutput("hs_ack_fall", {3'b0, ack_in}, 4'h0);
            checkOutput("hs_rise_count", 4'(ack_rises - iter), 4'h1);
            checkOutput("hs_fall_count", 4'(ack_falls - iter), 4'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
